// File: rtl/top.sv
// Four-digit multiplexed seven-segment driver.
// The switch value is synchronised through two flops and shown one digit at a time; each
// digit stays lit for REFRESH_DIV clock cycles. anode and cathode are active-low and registered.
// Optional macro DECIMAL_DISPLAY_EN: show the value in decimal with leading-zero blanking and
// dashes above 9999. When it is undefined, the four nibbles are shown as hex.
module top #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] switch,
  output logic [3:0]  anode,
  output logic [7:0]  cathode
);

  localparam int unsigned CntW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(REFRESH_DIV - 1);

  // Internal digit codes: 0..15 are hex values, plus two special symbols.
  localparam logic [4:0] CodeBlank = 5'd16;
  localparam logic [4:0] CodeDash  = 5'd17;

  logic [15:0]     sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      anode_q, anode_d;
  logic [7:0]      cathode_q, cathode_d;
  logic [4:0]      code_d;

  // Segment patterns, active-low, dp always off.
  function automatic logic [7:0] seg7(input logic [4:0] code);
    logic [7:0] s;
    case (code)
      5'd0:    s = 8'hC0;
      5'd1:    s = 8'hF9;
      5'd2:    s = 8'hA4;
      5'd3:    s = 8'hB0;
      5'd4:    s = 8'h99;
      5'd5:    s = 8'h92;
      5'd6:    s = 8'h82;
      5'd7:    s = 8'hF8;
      5'd8:    s = 8'h80;
      5'd9:    s = 8'h90;
      5'd10:   s = 8'h88;
      5'd11:   s = 8'h83;
      5'd12:   s = 8'hC6;
      5'd13:   s = 8'hA1;
      5'd14:   s = 8'h86;
      5'd15:   s = 8'h8E;
      5'd17:   s = 8'hBF;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Synchroniser, refresh counter, digit index and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      anode_q   <= 4'hF;
      cathode_q <= 8'hFF;
    end else begin
      sync1_q   <= switch;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
    end
  end

  // Refresh counter wraps at REFRESH_DIV-1 and steps the digit index on wrap.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == LastCnt) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

`ifdef DECIMAL_DISPLAY_EN
  logic [15:0] bcd;

  // Double-dabble binary-to-BCD; 14 input bits cover every value up to 9999.
  always_comb begin
    bcd = '0;
    for (int i = 13; i >= 0; i--) begin
      for (int n = 0; n < 4; n++) begin
        if (bcd[4*n +: 4] >= 4'd5) bcd[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
      end
      bcd = {bcd[14:0], sync2_q[i]};
    end
  end

  // Choose the digit for the upcoming index; blank leading zeros, dash on overflow.
  always_comb begin
    code_d = {1'b0, bcd[3:0]};
    if (sync2_q > 16'd9999) begin
      code_d = CodeDash;
    end else begin
      case (idx_d)
        2'd0: code_d = {1'b0, bcd[3:0]};
        2'd1: code_d = (sync2_q < 16'd10)   ? CodeBlank : {1'b0, bcd[7:4]};
        2'd2: code_d = (sync2_q < 16'd100)  ? CodeBlank : {1'b0, bcd[11:8]};
        default: code_d = (sync2_q < 16'd1000) ? CodeBlank : {1'b0, bcd[15:12]};
      endcase
    end
  end
`else
  // Hex mode: the digit is simply the selected nibble.
  always_comb begin
    code_d = {1'b0, sync2_q[{idx_d, 2'b00} +: 4]};
  end
`endif

  // Output next-state follows the new index so anode and cathode always agree.
  always_comb begin
    anode_d   = ~(4'b0001 << idx_d);
    cathode_d = seg7(code_d);
  end

  assign anode   = anode_q;
  assign cathode = cathode_q;

endmodule

// File: tb/tb_top.sv
// Directed bench for the seven-segment driver with REFRESH_DIV = 4.
module tb_top;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] switch = 16'h0000;
  logic [3:0]  anode;
  logic [7:0]  cathode;

  int n_vec = 0;
  int n_err = 0;

  top #(.REFRESH_DIV(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .switch  (switch),
    .anode   (anode),
    .cathode (cathode)
  );

  always #5 clock = ~clock;

  // Expected anode for the k-th rising edge after reset release (4 edges per digit).
  function automatic logic [3:0] exp_anode(input int k);
    logic [3:0] one;
    one = 4'b0001 << ((k / 4) % 4);
    return ~one;
  endfunction

  task automatic check_out(input string name, input logic [3:0] ea, input logic [7:0] ec);
    n_vec++;
    if (anode !== ea || cathode !== ec) begin
      n_err++;
      $display("FAIL %s: anode=%h cathode=%h, required anode=%h cathode=%h",
               name, anode, cathode, ea, ec);
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    switch = 16'h01E8;
    repeat (3) @(negedge clock);
    check_out("reset_hold", 4'hF, 8'hFF);
    reset = 1'b0;
    @(negedge clock);
    // sync2 still holds its reset value on the first edge, so digit 0 shows 0.
    check_out("reset_first_edge", 4'hE, 8'hC0);
  endtask

  // Reset, apply sw, then follow 20 edges; cathode checked once the synchroniser has filled.
  task automatic test_scan(input string name, input logic [15:0] sw,
                           input logic [7:0] c0, input logic [7:0] c1,
                           input logic [7:0] c2, input logic [7:0] c3);
    logic [7:0] ec;
    reset  = 1'b1;
    switch = sw;
    repeat (2) @(negedge clock);
    check_out({name, "_rst"}, 4'hF, 8'hFF);
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      case ((k / 4) % 4)
        0: ec = c0;
        1: ec = c1;
        2: ec = c2;
        default: ec = c3;
      endcase
      if (k < 3) begin
        n_vec++;
        if (anode !== exp_anode(k)) begin
          n_err++;
          $display("FAIL %s_anode k=%0d: got %h, required %h", name, k, anode, exp_anode(k));
        end
      end else begin
        check_out($sformatf("%s_k%0d", name, k), exp_anode(k), ec);
      end
    end
  endtask

  // 0 -> FFFF mid-digit: new digit value on the third edge, anode keeps its schedule.
  task automatic test_latency();
    reset  = 1'b1;
    switch = 16'h0000;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check_out("lat_before", exp_anode(5), 8'hC0);
    switch = 16'hFFFF;
    @(negedge clock);
    check_out("lat_edge1", exp_anode(6), 8'hC0);
    @(negedge clock);
    check_out("lat_edge2", exp_anode(7), 8'hC0);
    @(negedge clock);
`ifdef DECIMAL_DISPLAY_EN
    check_out("lat_edge3", exp_anode(8), 8'hBF);
`else
    check_out("lat_edge3", exp_anode(8), 8'h8E);
`endif
  endtask

  // Reset pulse between edges mid-scan; outputs clear at once and the scan restarts.
  task automatic test_async_reset();
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    #1 check_out("async_assert", 4'hF, 8'hFF);
    #1 reset = 1'b0;
    @(negedge clock);
    check_out("async_restart", 4'hE, 8'hC0);
    repeat (3) @(negedge clock);
`ifdef DECIMAL_DISPLAY_EN
    check_out("async_digit1", 4'hD, 8'hBF);
`else
    check_out("async_digit1", 4'hD, 8'h8E);
`endif
  endtask

  initial begin
    test_reset();
`ifdef DECIMAL_DISPLAY_EN
    test_scan("dec488", 16'd488, 8'h80, 8'h80, 8'h99, 8'hFF);
    test_scan("dec12345", 16'd12345, 8'hBF, 8'hBF, 8'hBF, 8'hBF);
    test_scan("dec0", 16'd0, 8'hC0, 8'hFF, 8'hFF, 8'hFF);
    test_scan("dec9999", 16'd9999, 8'h90, 8'h90, 8'h90, 8'h90);
    test_scan("dec10000", 16'd10000, 8'hBF, 8'hBF, 8'hBF, 8'hBF);
    test_scan("dec1024", 16'd1024, 8'h99, 8'hA4, 8'hC0, 8'hF9);
`else
    test_scan("hex01e8", 16'h01E8, 8'h80, 8'h86, 8'hF9, 8'hC0);
    test_scan("hex3039", 16'h3039, 8'h90, 8'hB0, 8'hC0, 8'hB0);
    test_scan("hexabcd", 16'hABCD, 8'hA1, 8'hC6, 8'h83, 8'h88);
    test_scan("hex5276", 16'h5276, 8'h82, 8'hF8, 8'hA4, 8'h92);
`endif
    test_latency();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
